// File: rtl/sccb_write_master.sv
// SCCB 3-phase write master: sends DEVICE_ID, sub-address and data, each followed by a
// released 9th bit whose sampled level feeds the sticky o_nack flag.
module sccb_write_master #(
  parameter int          CLK_FREQUENCY  = 25000000,
  parameter int          SCCB_FREQUENCY = 100000,
  parameter logic [7:0]  DEVICE_ID      = 8'h42
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_start,
  input  logic [7:0] i_address,
  input  logic [7:0] i_data,
  input  logic       i_sio_d,
  output logic       o_ready,
  output logic       o_sio_c,
  output logic       o_sio_d,
  output logic       o_sio_d_oe,
  output logic       o_nack
);

  localparam int QUARTER = CLK_FREQUENCY / (4 * SCCB_FREQUENCY);
  localparam int QW      = (QUARTER > 2) ? $clog2(QUARTER) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(QUARTER - 1);

  if (QUARTER < 2) begin : g_quarter_check
    $error("sccb_write_master: QUARTER must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_STOP,
    S_BUS_FREE
  } state_t;

  state_t          state, state_n;
  logic [QW-1:0]   qcnt, qcnt_n;
  logic [1:0]      quarter, quarter_n;
  logic [3:0]      bit_cnt, bit_n;
  logic [1:0]      phase, phase_n;
  logic [7:0]      addr_q, addr_n;
  logic [7:0]      data_q, data_n;
  logic            nack_n;
  logic            tick;
  logic [7:0]      cur_byte;
  logic            c_n, d_n, oe_n, ready_n;

  assign tick = (qcnt == Q_LAST);

  // Handshake: a request is taken on any rising edge where o_ready=1 and i_start=1;
  // o_ready drops on that same edge and i_start is not looked at again until o_ready returns.
  always_comb begin
    state_n   = state;
    qcnt_n    = tick ? '0 : qcnt + 1'b1;
    quarter_n = quarter;
    bit_n     = bit_cnt;
    phase_n   = phase;
    addr_n    = addr_q;
    data_n    = data_q;
    nack_n    = o_nack;
    case (state)
      S_IDLE: begin
        qcnt_n = '0;
        if (i_start) begin
          state_n   = S_START;
          quarter_n = 2'd0;
          bit_n     = 4'd0;
          phase_n   = 2'd0;
          addr_n    = i_address;
          data_n    = i_data;
          nack_n    = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          if (quarter == 2'd1) begin
            state_n   = S_BIT;
            quarter_n = 2'd0;
          end else begin
            quarter_n = quarter + 2'd1;
          end
        end
      end
      S_BIT: begin
        if (tick) begin
          // Slave answers in the 9th slot; sample at the end of the first C-high quarter.
          if (bit_cnt == 4'd8 && quarter == 2'd2 && i_sio_d) nack_n = 1'b1;
          if (quarter == 2'd3) begin
            quarter_n = 2'd0;
            if (bit_cnt == 4'd8) begin
              bit_n = 4'd0;
              if (phase == 2'd2) begin
                phase_n = 2'd0;
                state_n = S_STOP;
              end else begin
                phase_n = phase + 2'd1;
              end
            end else begin
              bit_n = bit_cnt + 4'd1;
            end
          end else begin
            quarter_n = quarter + 2'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (quarter == 2'd2) begin
            state_n   = S_BUS_FREE;
            quarter_n = 2'd0;
          end else begin
            quarter_n = quarter + 2'd1;
          end
        end
      end
      S_BUS_FREE: begin
        if (tick) begin
          if (quarter == 2'd3) begin
            state_n   = S_IDLE;
            quarter_n = 2'd0;
          end else begin
            quarter_n = quarter + 2'd1;
          end
        end
      end
      default: begin
        state_n   = S_IDLE;
        quarter_n = 2'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with the state.
  always_comb begin
    case (phase_n)
      2'd1:    cur_byte = addr_n;
      2'd2:    cur_byte = data_n;
      default: cur_byte = DEVICE_ID;
    endcase
    c_n     = 1'b1;
    d_n     = 1'b1;
    oe_n    = 1'b1;
    ready_n = (state_n == S_IDLE);
    case (state_n)
      S_START: begin
        c_n = (quarter_n == 2'd0);
        d_n = 1'b0;
      end
      S_BIT: begin
        c_n = quarter_n[1];
        if (bit_n == 4'd8) begin
          oe_n = 1'b0;
          d_n  = 1'b1;
        end else begin
          d_n = cur_byte[~bit_n[2:0]];
        end
      end
      S_STOP: begin
        c_n = (quarter_n != 2'd0);
        d_n = (quarter_n == 2'd2);
      end
      default: begin
        c_n = 1'b1;
        d_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= S_IDLE;
      qcnt       <= '0;
      quarter    <= 2'd0;
      bit_cnt    <= 4'd0;
      phase      <= 2'd0;
      addr_q     <= 8'd0;
      data_q     <= 8'd0;
      o_nack     <= 1'b0;
      o_ready    <= 1'b1;
      o_sio_c    <= 1'b1;
      o_sio_d    <= 1'b1;
      o_sio_d_oe <= 1'b1;
    end else begin
      state      <= state_n;
      qcnt       <= qcnt_n;
      quarter    <= quarter_n;
      bit_cnt    <= bit_n;
      phase      <= phase_n;
      addr_q     <= addr_n;
      data_q     <= data_n;
      o_nack     <= nack_n;
      o_ready    <= ready_n;
      o_sio_c    <= c_n;
      o_sio_d    <= d_n;
      o_sio_d_oe <= oe_n;
    end
  end

endmodule

// File: tb/tb_sccb_write_master.sv
// Directed bench for sccb_write_master: bus monitor with byte scoreboard and timing checks,
// plus a linear sequence of write, NACK, ignored-start, back-to-back and reset-abort steps.
`timescale 1ns/1ps
module tb_sccb_write_master;

  localparam int Q   = 62;
  localparam int TXN = 117 * Q;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] addr = 8'd0;
  logic [7:0] data = 8'd0;
  logic       sio_d_in;
  logic       ready, sio_c, sio_d, sio_d_oe, nack;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0]  nack_mask = 3'b000;
  logic [1:0]  ack_idx = 2'd0;
  logic [23:0] exp_q[$];

  logic        prev_c = 1'b1, prev_d = 1'b1, prev_oe = 1'b1;
  logic        in_tx = 1'b0;
  int          bits = 0;
  int          c_run = 0;
  int          idle_run = 4 * Q;
  int          stop_cnt = 0;
  logic [23:0] got = 24'd0;

  sccb_write_master dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_start    (start),
    .i_address  (addr),
    .i_data     (data),
    .i_sio_d    (sio_d_in),
    .o_ready    (ready),
    .o_sio_c    (sio_c),
    .o_sio_d    (sio_d),
    .o_sio_d_oe (sio_d_oe),
    .o_nack     (nack)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Slave model: drives the pad high in the acknowledge slots selected by nack_mask.
  assign sio_d_in = !sio_d_oe && (ack_idx != 2'd3) && nack_mask[ack_idx];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor and scoreboard
  always @(negedge clk) begin
    logic cc, dd;
    cc = sio_c;
    dd = sio_d_oe ? sio_d : 1'b1;
    if (!reset_n) begin
      in_tx    = 1'b0;
      bits     = 0;
      ack_idx  = 2'd0;
      c_run    = 0;
      idle_run = 4 * Q;
    end else begin
      if (cc && prev_c && prev_d && !dd) begin
        check("idle_before_start", 32'(idle_run >= 4 * Q), 1);
        check("start_outside_txn", 32'(in_tx), 0);
        in_tx   = 1'b1;
        bits    = 0;
        ack_idx = 2'd0;
        got     = 24'd0;
      end else if (cc && prev_c && !prev_d && dd) begin
        check("stop_bit_count", bits, 27);
        check("exp_q_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("bus_bytes", got, exp_q.pop_front());
        stop_cnt++;
        in_tx = 1'b0;
      end else if (!prev_c && cc && in_tx) begin
        check("d_stable_at_c_rise", dd, prev_d);
        check("c_low_time", c_run, (bits == 0) ? 3 * Q : (bits == 27) ? Q : 2 * Q);
        if (bits < 27) begin
          if (bits % 9 == 8) check("ack_slot_released", {sio_d_oe, sio_d}, 2'b01);
          else got = {got[22:0], sio_d};
          bits++;
        end
      end else if (prev_c && !cc && in_tx && bits > 0) begin
        check("c_high_time", c_run, 2 * Q);
      end
      if (!prev_oe && sio_d_oe && ack_idx != 2'd3) ack_idx = ack_idx + 2'd1;
      c_run    = (cc != prev_c) ? 1 : c_run + 1;
      idle_run = (cc && dd) ? idle_run + 1 : 0;
    end
    prev_c  = cc;
    prev_d  = dd;
    prev_oe = sio_d_oe;
  end

  // Driver tasks; both are entered and left at a falling clock edge.
  task automatic start_write(input logic [7:0] a, input logic [7:0] d, input bit hold,
                             input bit push);
    int cnt;
    cnt = 0;
    while (!ready && cnt < 20000) begin
      @(negedge clk);
      cnt++;
    end
    check("ready_before_start", ready, 1);
    start = 1'b1;
    addr  = a;
    data  = d;
    if (push) exp_q.push_back({8'h42, a, d});
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    addr = 8'($urandom_range(255));
    data = 8'($urandom_range(255));
    check("ready_low_after_accept", ready, 0);
    check("nack_cleared_on_accept", nack, 0);
    check("start_q0_bus", {sio_c, sio_d, sio_d_oe}, 3'b101);
  endtask

  task automatic wait_ready(input logic exp_nack, input int cnt0);
    int cnt;
    cnt = cnt0;
    while (!ready && cnt < TXN + 500) begin
      @(negedge clk);
      cnt++;
    end
    check("ready_latency", cnt, TXN);
    check("nack_at_ready", nack, exp_nack);
    check("idle_bus", {sio_c, sio_d, sio_d_oe}, 3'b111);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    repeat (3) @(negedge clk);
    check("reset_outputs", {ready, sio_c, sio_d, sio_d_oe, nack}, 5'b11110);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", {ready, sio_c, sio_d, sio_d_oe, nack}, 5'b11110);

    // Plain write, all acknowledged
    start_write(8'h12, 8'h80, 1'b0, 1'b1);
    wait_ready(1'b0, 0);

    // Slave refuses the data byte only
    nack_mask = 3'b100;
    start_write(8'h12, 8'h80, 1'b0, 1'b1);
    wait_ready(1'b1, 0);
    nack_mask = 3'b000;

    // Next start clears NACK; a mid-transfer start pulse is ignored
    s = stop_cnt;
    start_write(8'h12, 8'h80, 1'b0, 1'b1);
    repeat (100) @(negedge clk);
    start = 1'b1;
    addr  = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    check("ignored_start_ready", ready, 0);
    wait_ready(1'b0, 101);
    check("single_stop", stop_cnt, s + 1);

    // Start held high: two back-to-back transactions
    s = stop_cnt;
    start_write(8'h3A, 8'h04, 1'b1, 1'b1);
    exp_q.push_back({8'h42, 8'h3A, 8'h04});
    addr = 8'h3A;
    data = 8'h04;
    wait_ready(1'b0, 0);
    @(negedge clk);
    check("ready_one_cycle", ready, 0);
    addr = 8'h00;
    wait_ready(1'b0, 0);
    start = 1'b0;
    @(negedge clk);
    check("no_third_txn", ready, 1);
    check("two_stops", stop_cnt, s + 2);

    // Reset during the address phase aborts without a STOP
    s = stop_cnt;
    start_write(8'h55, 8'hAA, 1'b0, 1'b0);
    repeat (3000) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {ready, sio_c, sio_d, sio_d_oe, nack}, 5'b11110);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("no_stop_on_abort", stop_cnt, s);
    start_write(8'h11, 8'h01, 1'b0, 1'b1);
    wait_ready(1'b0, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("total_stops", stop_cnt, 6);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sccb_write_master.md
SCCB_WRITE_MASTER -- requirements
Module: sccb_write_master

Interface
REQ-001 Parameter CLK_FREQUENCY, default 25000000, i_clk frequency in Hz.
REQ-002 Parameter SCCB_FREQUENCY, default 100000, nominal SIO_C frequency in Hz.
REQ-003 Parameter DEVICE_ID, default 8'h42, 8-bit write ID sent as the first phase of every transaction.
REQ-004 Derived QUARTER = CLK_FREQUENCY / (4*SCCB_FREQUENCY) by integer division (62 at defaults); elaboration SHALL fail if QUARTER < 2.
REQ-005 i_clk  input  1  system clock, all logic on rising edge.
REQ-006 i_reset_n  input  1  asynchronous, active-low reset.
REQ-007 i_start  input  1  transaction request, sampled only while o_ready=1.
REQ-008 i_address  input  8  register sub-address, latched at accepted start.
REQ-009 i_data  input  8  register write data, latched at accepted start.
REQ-010 i_sio_d  input  1  sampled SIO_D pad value, used for the 9th-bit check.
REQ-011 o_ready  output  1  high when idle and able to accept i_start.
REQ-012 o_sio_c  output  1  SIO_C line, always driven.
REQ-013 o_sio_d  output  1  SIO_D output value.
REQ-014 o_sio_d_oe  output  1  SIO_D drive enable; 0 = released (pad high-Z).
REQ-015 o_nack  output  1  1 = last transaction saw SIO_D high in at least one 9th-bit slot.

Function
REQ-016 Timing SHALL be built from a quarter counter producing a tick every QUARTER i_clk cycles; all phase durations are whole quarters.
REQ-017 States: IDLE, START, BIT, STOP, BUS_FREE; IDLE drives C=1, D=1, oe=1, o_ready=1.
REQ-018 In IDLE, i_start=1 at a rising edge SHALL latch i_address/i_data, clear o_nack, deassert o_ready on that same edge, enter START.
REQ-019 i_start while o_ready=0 SHALL be ignored; i_start held high SHALL start a new transaction on the first edge o_ready is 1.
REQ-020 START, 2 quarters: q0 C=1 D=0; q1 C=0 D=0.
REQ-021 BIT: 27 bit slots = 3 phases (DEVICE_ID, address, data) x 9 bits, each phase 8 data bits MSB first then one 9th bit.
REQ-022 Each bit slot is 4 quarters: q0,q1 C=0; q2,q3 C=1; D updated at start of q0 and stable for the slot.
REQ-023 In 9th-bit slots o_sio_d_oe=0 and o_sio_d=1; oe=1 in all other slots and states.
REQ-024 i_sio_d SHALL be sampled on the edge ending q2 of each 9th-bit slot; sample 1 sets o_nack (sticky until next accepted start); transaction continues regardless.
REQ-025 STOP, 3 quarters: q0 C=0 D=0; q1 C=1 D=0; q2 C=1 D=1.
REQ-026 BUS_FREE, 4 quarters: C=1 D=1 oe=1, then return to IDLE with o_ready=1.
REQ-027 o_ready SHALL rise exactly 117*QUARTER cycles after the accepting edge (7254 at defaults).
REQ-028 Bit counter 0..8 and phase counter 0..2 SHALL wrap to 0 after 8 and 2 respectively; no other wrap permitted mid-transaction.
REQ-029 i_address/i_data changes after acceptance SHALL NOT affect the transfer in progress.
REQ-030 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-031 i_reset_n=0 SHALL immediately force: state IDLE, o_ready=1, o_sio_c=1, o_sio_d=1, o_sio_d_oe=1, o_nack=0, all counters and latches 0.
REQ-032 Reset asserted mid-transaction SHALL abort without generating a STOP; after release the block is in IDLE and accepts i_start on the next edge.

Verification
REQ-033 Write addr 8'h12 data 8'h80, i_sio_d=0 -> SIO_D at q2 edges reads 0x42,Z,0x12,Z,0x80,Z, o_nack=0, o_ready high after 7254 cycles.
REQ-034 Same write, i_sio_d=1 during data-phase 9th bit only -> o_nack=1 at o_ready rise; next accepted start clears o_nack to 0.
REQ-035 i_start pulsed 100 cycles into a transfer with addr 8'hFF -> ignored; bus shows original bytes, single STOP.
REQ-036 i_start held high continuously, addr 8'h3A data 8'h04 -> back-to-back transactions, o_ready high exactly 1 cycle between them, 4 quarters C=1 D=1 preceding each START.
REQ-037 i_reset_n low for 3 cycles during address phase -> outputs idle within the reset assertion, no STOP; next write 8'h11/8'h01 completes normally.
REQ-038 Protocol checker on every transaction: D changes only while C=0 except START (q0) and STOP (q2) edges; C high time 2*QUARTER, low time 2*QUARTER per bit.
